input_capture: RTL and testbench

- Player-side input front end for the game datapath, on the opposite end of the switch-to-compare path from the pattern/score display.
- Debounces the 4 raw SW inputs.
- Captures one player answer per round.
- Measures reaction time in timebase ticks.
- Holds the answer stable for the round comparator until the next round starts.

---
 rtl/input_capture.sv | 152 +++++++++++++++
 tb/tb_input_capture.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/input_capture.sv
// Player input front end: synchronises and debounces SW, captures one answer per round, times the reaction.
// Build option INPUT_CAPTURE_STRICT_RELEASE_EN: all switches must be released after round_start before a capture is allowed.
module input_capture #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIME_W          = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        SW,
    input  logic              round_start,
    input  logic              tick,
    output logic [3:0]        cap_input,
    output logic              cap_valid,
    output logic [TIME_W-1:0] reaction_time,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        WAIT   = 2'd2,
        LOCKED = 2'd3
    } state_t;

    localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

    logic [3:0]        r_sync1;
    logic [3:0]        r_sync2;
    logic [3:0]        r_deb;
    logic [3:0][7:0]   r_cnt;
    state_t            r_state;
    logic [3:0]        r_cap;
    logic              r_valid;
    logic [TIME_W-1:0] r_rt;

    state_t            w_state_nxt;
    logic [3:0]        w_cap_nxt;
    logic              w_valid_nxt;
    logic [TIME_W-1:0] w_rt_nxt;
    logic [TIME_W-1:0] w_rt_inc;

    // Two-flop synchroniser for the asynchronous switch levels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 4'b0000;
            r_sync2 <= 4'b0000;
        end else begin
            r_sync1 <= SW;
            r_sync2 <= r_sync1;
        end
    end

    // Per-bit debounce: flip only after a mismatch persists for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_deb <= 4'b0000;
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_cnt[i] <= 8'd0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_deb[i] <= r_sync2[i];
                    r_cnt[i] <= 8'd0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 8'd1;
                end
            end
        end
    end

    assign w_rt_inc = (r_rt == {TIME_W{1'b1}}) ? r_rt : r_rt + TIME_W'(1);

    // Next-state and next-output logic; round_start overrides everything else.
    always_comb begin
        w_state_nxt = r_state;
        w_cap_nxt   = r_cap;
        w_valid_nxt = r_valid;
        w_rt_nxt    = r_rt;
        if (round_start) begin
`ifdef INPUT_CAPTURE_STRICT_RELEASE_EN
            w_state_nxt = ARMED;
`else
            w_state_nxt = WAIT;
`endif
            w_cap_nxt   = 4'b0000;
            w_valid_nxt = 1'b0;
            w_rt_nxt    = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = IDLE;
                end
                ARMED: begin
`ifdef INPUT_CAPTURE_STRICT_RELEASE_EN
                    if (r_deb == 4'b0000) begin
                        w_state_nxt = WAIT;
                    end else begin
                        w_state_nxt = ARMED;
                    end
`else
                    w_state_nxt = WAIT;
`endif
                    if (tick) begin
                        w_rt_nxt = w_rt_inc;
                    end else begin
                        w_rt_nxt = r_rt;
                    end
                end
                WAIT: begin
                    // A tick landing on the capture cycle is deliberately not counted.
                    if (r_deb != 4'b0000) begin
                        w_state_nxt = LOCKED;
                        w_cap_nxt   = r_deb;
                        w_valid_nxt = 1'b1;
                    end else if (tick) begin
                        w_rt_nxt = w_rt_inc;
                    end else begin
                        w_rt_nxt = r_rt;
                    end
                end
                LOCKED: begin
                    w_state_nxt = LOCKED;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cap   <= 4'b0000;
            r_valid <= 1'b0;
            r_rt    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cap   <= w_cap_nxt;
            r_valid <= w_valid_nxt;
            r_rt    <= w_rt_nxt;
        end
    end

    assign cap_input     = r_cap;
    assign cap_valid     = r_valid;
    assign reaction_time = r_rt;
    assign state         = r_state;

endmodule

// File: tb/tb_input_capture.sv
// Scoreboard bench for input_capture: expected captures are queued at stimulus time and checked on cap_valid rise.
module tb_input_capture;

    localparam int DEB = 16;
    localparam int TW  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    sw = 4'b0000;
    logic          round_start = 1'b0;
    logic          tick = 1'b0;
    logic [3:0]    cap_input;
    logic          cap_valid;
    logic [TW-1:0] reaction_time;
    logic [1:0]    state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic prev_valid = 1'b0;

    typedef struct {
        logic [3:0]    inp;
        logic [TW-1:0] rt;
        int            cyc;
    } exp_t;

    exp_t sb[$];

    input_capture #(.DEBOUNCE_CYCLES(DEB), .TIME_W(TW)) dut (
        .clk(clk), .rst(rst), .SW(sw), .round_start(round_start), .tick(tick),
        .cap_input(cap_input), .cap_valid(cap_valid),
        .reaction_time(reaction_time), .state(state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Scoreboard monitor: every rising cap_valid must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid <= 1'b0;
        end else begin
            if (cap_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    check_value("cap_unexpected", 32'(sb.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_value("cap_input", 32'(cap_input), 32'(e.inp));
                    check_value("cap_rt", 32'(reaction_time), 32'(e.rt));
                    check_value("cap_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            prev_valid <= cap_valid;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_round();
        round_start = 1'b1;
        step(1);
        round_start = 1'b0;
    endtask

    task automatic wait_sb();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 200) begin
            step(1);
            k++;
        end
        check_value("sb_drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int e0;
        // Reset and idle behaviour
        rst = 1'b1; sw = 4'b1010;
        step(3);
        rst = 1'b0;
        step(5);
        #2 rst = 1'b1;
        #1;
        check_value("rst_state", 32'(state), 32'd0);
        check_value("rst_valid", 32'(cap_valid), 32'd0);
        check_value("rst_input", 32'(cap_input), 32'd0);
        check_value("rst_rt", 32'(reaction_time), 32'd0);
        step(2);
        rst = 1'b0;
        step(100);
        @(negedge clk);
        check_value("idle_valid", 32'(cap_valid), 32'd0);
        check_value("idle_state", 32'(state), 32'd0);

        // Glitch rejection
        sw = 4'b0000;
        step(DEB + 8);
        pulse_round();
        step(20);
        sw = 4'b0100;
        step(DEB - 2);
        sw = 4'b0000;
        step(30);
        @(negedge clk);
        check_value("glitch_valid", 32'(cap_valid), 32'd0);
        check_value("glitch_state", 32'(state), 32'd2);

        // Normal capture with three ticks
        step(1);
        pulse_round();
        repeat (3) begin
            tick = 1'b1; step(1);
            tick = 1'b0; step(1);
        end
        step(2);
        sw = 4'b0100;
        sb.push_back('{4'b0100, TW'(3), cyc + DEB + 3});
        wait_sb();
        sw = 4'b1111;
        tick = 1'b1;
        step(DEB + 10);
        tick = 1'b0;
        @(negedge clk);
        check_value("lock_input", 32'(cap_input), 32'h4);
        check_value("lock_rt", 32'(reaction_time), 32'd3);
        check_value("lock_state", 32'(state), 32'd3);

        // Held-switch carryover; tick coincident with round_start
        step(1);
        sw = 4'b0001;
        step(DEB + 8);
`ifdef INPUT_CAPTURE_STRICT_RELEASE_EN
        tick = 1'b1;
        pulse_round();
        tick = 1'b0;
        step(30);
        @(negedge clk);
        check_value("carry_state", 32'(state), 32'd1);
        check_value("carry_valid", 32'(cap_valid), 32'd0);
        check_value("carry_rt", 32'(reaction_time), 32'd0);
        step(1);
        sw = 4'b0000;
        step(DEB + 8);
        @(negedge clk);
        check_value("release_state", 32'(state), 32'd2);
        step(1);
        sw = 4'b0010;
        sb.push_back('{4'b0010, TW'(0), cyc + DEB + 3});
        wait_sb();
`else
        tick = 1'b1;
        round_start = 1'b1;
        sb.push_back('{4'b0001, TW'(0), cyc + 2});
        step(1);
        round_start = 1'b0;
        tick = 1'b0;
        wait_sb();
        @(negedge clk);
        check_value("carry_state", 32'(state), 32'd3);
        step(1);
`endif
        sw = 4'b0000;
        step(DEB + 8);

        // Saturation
        pulse_round();
        tick = 1'b1;
        step(300);
        sw = 4'b1000;
        sb.push_back('{4'b1000, {TW{1'b1}}, cyc + DEB + 3});
        wait_sb();
        tick = 1'b0;

        // round_start wins over a same-cycle capture
        sw = 4'b0000;
        step(DEB + 8);
        pulse_round();
        step(5);
        sw = 4'b0100;
        e0 = cyc;
        step(DEB + 2);
        check_value("prio_align", 32'(cyc), 32'(e0 + DEB + 2));
        round_start = 1'b1;
`ifndef INPUT_CAPTURE_STRICT_RELEASE_EN
        sb.push_back('{4'b0100, TW'(0), cyc + 2});
`endif
        step(1);
        round_start = 1'b0;
        @(negedge clk);
        check_value("prio_valid", 32'(cap_valid), 32'd0);
`ifdef INPUT_CAPTURE_STRICT_RELEASE_EN
        check_value("prio_state", 32'(state), 32'd1);
        step(10);
        @(negedge clk);
        check_value("prio_hold_valid", 32'(cap_valid), 32'd0);
`else
        check_value("prio_state", 32'(state), 32'd2);
        wait_sb();
`endif

        // Asynchronous reset mid-cycle from an active state
        step(1);
        #2 rst = 1'b1;
        #1;
        check_value("rst2_state", 32'(state), 32'd0);
        check_value("rst2_valid", 32'(cap_valid), 32'd0);
        check_value("rst2_input", 32'(cap_input), 32'd0);
        check_value("rst2_rt", 32'(reaction_time), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
